seq_divider: RTL and testbench

- Multi-cycle signed integer divider; the inverse datapath of the team's sequential shift-add multiplier.
- Uses the same start/ready handshake as the multiplier, so the same driver/monitor bench style applies to both.
- Computes one quotient bit per clock with restoring division on operand magnitudes, then applies a sign-fix cycle.
- Sits beside the multiplier in the sequential arithmetic library.

---
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider, restoring division on magnitudes plus a sign-fix cycle.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             ready,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             div_by_zero
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH:0]   dvs_q, dvs_d;
   logic             sa_q, sa_d, sb_q, sb_d, zero_q, zero_d;
   logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
   logic             ready_q, ready_d, dbz_q, dbz_d;
   logic [WIDTH+1:0] shifted, diff;
   logic             accept;

   // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom
   always_comb begin
      shifted = {rem_q, dvd_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      accept  = (state_q == IDLE || state_q == DONE) && start;
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      zero_d  = zero_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      ready_d = ready_q;
      dbz_d   = dbz_q;
      if (accept) begin
         state_d = CALC;
         cnt_d   = '0;
         rem_d   = '0;
         dvd_d   = Dividend[WIDTH-1] ? -Dividend : Dividend;
         dvs_d   = {1'b0, Divisor[WIDTH-1] ? -Divisor : Divisor};
         sa_d    = Dividend[WIDTH-1];
         sb_d    = Divisor[WIDTH-1];
         zero_d  = Divisor == '0;
         ready_d = 1'b0;
         dbz_d   = 1'b0;
      end else if (state_q == CALC) begin
         rem_d   = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
         dvd_d   = {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
         cnt_d   = cnt_q + 1'b1;
         state_d = (cnt_q == LAST) ? FIX : CALC;
      end else if (state_q == FIX) begin
         quot_d  = zero_q ? '1 : (sa_q ^ sb_q) ? -dvd_q : dvd_q;
         remo_d  = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
         ready_d = 1'b1;
         dbz_d   = zero_q;
         state_d = DONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         ready_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         zero_q  <= zero_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         ready_q <= ready_d;
         dbz_q   <= dbz_d;
      end
   end

   assign ready       = ready_q;
   assign Quotient    = quot_q;
   assign Remainder   = remo_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against a behavioural model.
module tb_seq_divider;
   localparam int W = 16;
   localparam int LAT = W + 1;

   logic clk = 1'b0;
   logic rst, start;
   logic [W-1:0] Dividend, Divisor, Quotient, Remainder;
   logic ready, div_by_zero;
   int total = 0;
   int bad = 0;
   int n;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .Dividend(Dividend), .Divisor(Divisor),
      .ready(ready), .Quotient(Quotient), .Remainder(Remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] qf(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      int ai = a;
      int bi = b;
      return (bi == 0) ? '1 : W'(ai / bi);
   endfunction

   function automatic logic [W-1:0] rf(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      int ai = a;
      int bi = b;
      return (bi == 0) ? a : W'(ai % bi);
   endfunction

   // Model: an accepted request yields its result LAT edges later; outputs otherwise hold
   int m_cnt;
   logic m_ready, m_z;
   logic [W-1:0] m_q, m_r, m_a, m_b;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt <= 0; m_ready <= 1'b0; m_z <= 1'b0; m_q <= '0; m_r <= '0; m_a <= '0; m_b <= '0;
      end else if (m_cnt == 0 && start) begin
         m_cnt <= LAT; m_ready <= 1'b0; m_z <= 1'b0; m_a <= Dividend; m_b <= Divisor;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_ready <= 1'b1; m_z <= (m_b == '0); m_q <= qf(m_a, m_b); m_r <= rf(m_a, m_b);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         total++;
         if ({ready, div_by_zero, Quotient, Remainder} !== {m_ready, m_z, m_q, m_r}) begin
            bad++;
            $display("FAIL model_cmp t=%0t: ready=%b dbz=%b Q=%0d R=%0d, want ready=%b dbz=%b Q=%0d R=%0d",
                     $time, ready, div_by_zero, $signed(Quotient), $signed(Remainder),
                     m_ready, m_z, $signed(m_q), $signed(m_r));
         end
      end
   end

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 60) begin
         @(posedge clk); #2;
         cnt++;
      end
   endtask

   task automatic op(input int a, input int b, input bit lit, input int eq, input int er, input int ez);
      int c;
      @(posedge clk); #2;
      Dividend = W'(a); Divisor = W'(b); start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      chk("ready_clear", ready, 0);
      wait_ready(c);
      chk("latency", c, LAT);
      if (lit) begin
         chk("quot", $signed(Quotient), eq);
         chk("rem", $signed(Remainder), er);
         chk("dbz", div_by_zero, ez);
      end
   endtask

   int ta[10] = '{100, -100, 100, -100, 3, 0, 5, -32768, -32768, 32767};
   int tb_[10] = '{7, 7, -7, -7, 10, -5, 0, -1, 1, -32768};
   int tq[10] = '{14, -14, -14, 14, 0, 0, -1, -32768, -32768, 0};
   int tr[10] = '{2, -2, 2, -2, 3, 0, 5, 0, 0, 32767};
   int tz[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

   initial begin
      rst = 1'b0; start = 1'b0; Dividend = '0; Divisor = '0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_quot", $signed(Quotient), 0);
      chk("rst_rem", $signed(Remainder), 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 10; i++) op(ta[i], tb_[i], 1'b1, tq[i], tr[i], tz[i]);
      // start and operand changes during CALC must be ignored
      @(posedge clk); #2;
      Dividend = W'(100); Divisor = W'(7); start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      start = 1'b1; Dividend = W'(9); Divisor = W'(3);
      @(posedge clk); #2;
      start = 1'b0;
      wait_ready(n);
      chk("ignore_lat", n, LAT - 4);
      chk("ignore_quot", $signed(Quotient), 14);
      chk("ignore_rem", $signed(Remainder), 2);
      // start held high through DONE re-accepts on the next edge
      @(posedge clk); #2;
      Dividend = W'(-100); Divisor = W'(-7); start = 1'b1;
      @(posedge clk); #2;
      wait_ready(n);
      chk("held_lat", n, LAT);
      chk("held_quot", $signed(Quotient), 14);
      @(posedge clk); #2;
      chk("held_drop", ready, 0);
      start = 1'b0;
      wait_ready(n);
      chk("held_lat2", n, LAT);
      chk("held_rem", $signed(Remainder), -2);
      // asynchronous reset in the middle of CALC
      @(posedge clk); #2;
      Dividend = W'(100); Divisor = W'(7); start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ready", ready, 0);
      chk("arst_quot", $signed(Quotient), 0);
      chk("arst_rem", $signed(Remainder), 0);
      chk("arst_dbz", div_by_zero, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      op(50, 5, 1'b1, 10, 0, 0);
      for (int i = 0; i < 50; i++) begin
         int a, b;
         a = int'($urandom_range(0, 65535));
         b = (i % 3 == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 65535));
         if (i % 5 == 0) b = -b;
         op(a, b, 1'b0, 0, 0, 0);
      end
      for (int i = 0; i < 5; i++) begin
         int a;
         a = int'($urandom_range(0, 65535));
         op(a, 0, 1'b1, -1, int'($signed(W'(a))), 1);
      end
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
